// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter and issue sequencer for the shared ALU.
// Grants one op per cycle (round-robin, with an optional bounded lock), registers
// the winning operands onto the ALU inputs and captures the ALU result/flags one
// cycle later into a tagged response register.
// Ports:
//   Clk, Reset            clock (rising edge), async active-high reset
//   reqN/lockN/opN/aN/bN/scN  requester N inputs, held stable until ackN
//   ack0/ack1             combinational accept strobes
//   alu_op/alu_a/alu_b/alu_sc  registered ALU inputs
//   alu_out/alu_zero/alu_parity/alu_odd  ALU result and flags (combinational)
//   rsp_valid/rsp_id/rsp_data/rsp_zero/rsp_parity/rsp_odd  response register
module alu_arbiter #(
  parameter int unsigned W       = 8,
  parameter int unsigned Ops     = 4,
  parameter int unsigned MAXLOCK = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           req0,
  input  logic           req1,
  input  logic           lock0,
  input  logic           lock1,
  input  logic [Ops-1:0] op0,
  input  logic [Ops-1:0] op1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   b1,
  input  logic           sc0,
  input  logic           sc1,
  output logic           ack0,
  output logic           ack1,
  output logic [Ops-1:0] alu_op,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_sc,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zero,
  input  logic           alu_parity,
  input  logic           alu_odd,
  output logic           rsp_valid,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_zero,
  output logic           rsp_parity,
  output logic           rsp_odd
);

  localparam int unsigned CW = 4;

  typedef enum logic {ST_FREE, ST_LOCKED} lock_state_e;

  lock_state_e   state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_gnt_q;
  logic          issue_valid_q;
  logic          issue_id_q;

  logic          gnt_valid;
  logic          gnt_id;
  logic          owner_req;
  logic          lock_live;
  logic          win_lock;

  // Lock state register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_FREE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration and lock next-state; a saturated lock falls back to round-robin.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    owner_req = owner_q ? req1 : req0;
    lock_live = (state_q == ST_LOCKED) && owner_req && (cnt_q < CW'(MAXLOCK));

    if (lock_live) begin
      gnt_valid = 1'b1;
      gnt_id    = owner_q;
    end else if (req0 && req1) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last_gnt_q;
    end else if (req0) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (req1) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end

    win_lock = gnt_id ? lock1 : lock0;

    if (lock_live) begin
      if (win_lock) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        state_d = ST_FREE;
        cnt_d   = '0;
      end
    end else if (gnt_valid && win_lock) begin
      // Fresh lock, including right after a forced release.
      state_d = ST_LOCKED;
      owner_d = gnt_id;
      cnt_d   = CW'(1);
    end else begin
      state_d = ST_FREE;
      cnt_d   = '0;
    end
  end

  // Acks are suppressed while reset is asserted.
  assign ack0 = gnt_valid && !gnt_id && !Reset;
  assign ack1 = gnt_valid &&  gnt_id && !Reset;

  // Issue stage: load the winner's operands onto the ALU inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      alu_op        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sc        <= 1'b0;
      issue_valid_q <= 1'b0;
      issue_id_q    <= 1'b0;
      last_gnt_q    <= 1'b1;
    end else begin
      issue_valid_q <= gnt_valid;
      if (gnt_valid) begin
        alu_op     <= gnt_id ? op1 : op0;
        alu_a      <= gnt_id ? a1  : a0;
        alu_b      <= gnt_id ? b1  : b0;
        alu_sc     <= gnt_id ? sc1 : sc0;
        issue_id_q <= gnt_id;
        last_gnt_q <= gnt_id;
      end
    end
  end

  // Response stage: capture ALU result one cycle after issue.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_parity <= 1'b0;
      rsp_odd    <= 1'b0;
    end else begin
      rsp_valid <= issue_valid_q;
      if (issue_valid_q) begin
        rsp_id     <= issue_id_q;
        rsp_data   <= alu_out;
        rsp_zero   <= alu_zero;
        rsp_parity <= alu_parity;
        rsp_odd    <= alu_odd;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter with a small ALU model
// (op 0 = ADD, op 1 = SUB, others = XOR; parity = XOR-reduce, odd = bit 0).
module tb_alu_arbiter;

  localparam int unsigned W   = 8;
  localparam int unsigned OPS = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           req0 = 1'b0, req1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [OPS-1:0] op0 = '0, op1 = '0;
  logic [W-1:0]   a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic           sc0 = 1'b0, sc1 = 1'b0;
  logic           ack0, ack1;
  logic [OPS-1:0] alu_op;
  logic [W-1:0]   alu_a, alu_b, alu_out;
  logic           alu_sc, alu_zero, alu_parity, alu_odd;
  logic           rsp_valid, rsp_id, rsp_zero, rsp_parity, rsp_odd;
  logic [W-1:0]   rsp_data;

  int n_assert = 0;
  int n_fail   = 0;

  // Expected results per requester for the operands currently driven.
  logic [W-1:0] d0, d1;
  // Expected response pipeline (ack one and two cycles ago).
  logic         v_d1 = 1'b0, v_d2 = 1'b0, id_d1 = 1'b0, id_d2 = 1'b0;
  logic [W-1:0] dd1 = '0, dd2 = '0;

  always #5 clk = ~clk;

  alu_arbiter #(.W(W), .Ops(OPS), .MAXLOCK(4)) dut (
    .Clk(clk), .Reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .op0(op0), .op1(op1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .sc0(sc0), .sc1(sc1), .ack0(ack0), .ack1(ack1),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_sc(alu_sc),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_parity(alu_parity), .alu_odd(alu_odd),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_parity(rsp_parity), .rsp_odd(rsp_odd)
  );

  always_comb begin
    case (alu_op)
      4'h0:    alu_out = alu_a + alu_b;
      4'h1:    alu_out = alu_a - alu_b;
      default: alu_out = alu_a ^ alu_b;
    endcase
    alu_zero   = (alu_out == '0);
    alu_parity = ^alu_out;
    alu_odd    = alu_out[0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check acks and the response due now, then advance to edge + 1.
  task automatic tick(input logic e0, input logic e1);
    #1;
    chk("ack0", 32'(ack0), 32'(e0));
    chk("ack1", 32'(ack1), 32'(e1));
    chk("rsp_valid", 32'(rsp_valid), 32'(v_d2));
    if (v_d2) begin
      chk("rsp_id", 32'(rsp_id), 32'(id_d2));
      chk("rsp_data", 32'(rsp_data), 32'(dd2));
    end
    v_d2  = v_d1;
    id_d2 = id_d1;
    dd2   = dd1;
    v_d1  = e0 | e1;
    id_d1 = e1;
    dd1   = e1 ? d1 : d0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: outputs held at zero even with a request pending.
    req0 = 1'b1; op0 = 4'h0; a0 = 8'h05; b0 = 8'h03; d0 = 8'h08; d1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b0;

    // ADD 5 + 3 from requester 0 alone.
    tick(1'b1, 1'b0);
    req0 = 1'b0;
    chk("t1_alu_a", 32'(alu_a), 32'h05);
    chk("t1_alu_b", 32'(alu_b), 32'h03);
    chk("t1_alu_op", 32'(alu_op), 32'h0);
    tick(1'b0, 1'b0);
    chk("t1_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("t1_rsp_parity", 32'(rsp_parity), 32'd1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Lock saturation: req1 locked for 6 cycles, req0 high throughout.
    op0 = 4'h0; a0 = 8'h10; b0 = 8'h01; d0 = 8'h11;
    op1 = 4'h0; a1 = 8'h20; b1 = 8'h02; d1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1; lock1 = 1'b1;
    repeat (4) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    req1 = 1'b0; lock1 = 1'b0;
    tick(1'b1, 1'b0);
    req0 = 1'b0;
    repeat (3) tick(1'b0, 1'b0);

    // Lock for two grants, released by lock1=0 on the third.
    req0 = 1'b1; req1 = 1'b1; lock1 = 1'b1;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    lock1 = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick(1'b0, 1'b0);

    // SUB 3C - 3C from requester 1: zero result.
    op1 = 4'h1; a1 = 8'h3C; b1 = 8'h3C; sc1 = 1'b1; d1 = 8'h00;
    req1 = 1'b1;
    tick(1'b0, 1'b1);
    req1 = 1'b0;
    chk("sub_alu_op", 32'(alu_op), 32'h1);
    chk("sub_alu_sc", 32'(alu_sc), 32'd1);
    tick(1'b0, 1'b0);
    chk("sub_rsp_zero", 32'(rsp_zero), 32'd1);
    chk("sub_rsp_parity", 32'(rsp_parity), 32'd0);
    chk("sub_rsp_odd", 32'(rsp_odd), 32'd0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);

    // Round-robin alternation with both requesting.
    op1 = 4'h0; a1 = 8'h20; b1 = 8'h02; sc1 = 1'b0; d1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick(1'b0, 1'b0);

    // Reset the cycle after ack0: the in-flight op is discarded.
    a0 = 8'h40; b0 = 8'h04; d0 = 8'h44;
    req0 = 1'b1;
    tick(1'b1, 1'b0);
    req0 = 1'b0; req1 = 1'b1; reset = 1'b1;
    #1;
    chk("mid_rst_ack1", 32'(ack1), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    chk("mid_rst_alu_op", 32'(alu_op), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    v_d1 = 1'b0; v_d2 = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_rsp_valid2", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    tick(1'b0, 1'b1);
    req1 = 1'b0;
    chk("post_rst_alu_a", 32'(alu_a), 32'h20);
    repeat (3) tick(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
